cmd_seq_multi: RTL

- Parametrised successor to the single-channel FE-I4 command sequencer.
- Stores a bit pattern in internal byte memory loaded over the 8-bit register bus, and serialises it MSB-first at one bit per BUS_CLK.
- Drives up to N_CH FE command lines, each gated by an enable mask.
- Adds programmable repeat count, continuous mode, external start trigger and readback; it sits between the bus decoder and the CMD_DATA pads.

---
 rtl/cmd_seq_multi.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cmd_seq_multi.sv
// Multi-channel FE command sequencer: a bus-loaded pattern memory is sent MSB-first,
// one bit per BUS_CLK, onto N_CH enable-gated command lines, with repeat, continuous and external-start modes.
module cmd_seq_multi #(
  parameter int unsigned BASEADDR  = 16'h0000,
  parameter int unsigned HIGHADDR  = 16'h00FF,
  parameter int unsigned ABUSWIDTH = 16,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 EXT_START,
  output logic [N_CH-1:0]      CMD_DATA,
  output logic                 CMD_READY,
  output logic                 CMD_START_FLAG
);
  localparam int unsigned          AW       = $clog2(MEM_BYTES);
  localparam logic [ABUSWIDTH:0]   BASE_X   = (ABUSWIDTH+1)'(BASEADDR);
  localparam logic [ABUSWIDTH-1:0] SPAN     = ABUSWIDTH'(HIGHADDR - BASEADDR);
  localparam logic [ABUSWIDTH-1:0] MEM_LO   = ABUSWIDTH'(16);
  localparam logic [ABUSWIDTH-1:0] MEM_HI   = ABUSWIDTH'(16 + MEM_BYTES);
  localparam logic [ABUSWIDTH-1:0] REG_HI   = ABUSWIDTH'(8);
  localparam logic [ABUSWIDTH-1:0] OFF_STRT = ABUSWIDTH'(1);
  localparam logic [16:0]          MEM_BITS = 17'(MEM_BYTES * 8);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_t;

  state_t          r_state;
  logic [15:0]     r_size;
  logic [15:0]     r_rep;
  logic [N_CH-1:0] r_ch_en;
  logic [1:0]      r_mode;
  logic [16:0]     r_idx;
  logic [16:0]     r_pass;
  logic [7:0]      r_byte;
  logic            r_ext_d;
  logic [7:0]      r_mem [MEM_BYTES];
  logic [N_CH-1:0] r_cmd;
  logic            r_ready;
  logic            r_flag;
  logic [7:0]      r_rdata;

  logic [ABUSWIDTH:0]   w_diff;
  logic [ABUSWIDTH-1:0] w_off;
  logic                 w_in_range;
  logic                 w_is_mem;
  logic                 w_is_reg;
  logic [AW-1:0]        w_mem_addr;
  logic                 w_wr;
  logic                 w_soft_rst;
  logic                 w_start;
  logic [16:0]          w_esize;
  logic [2:0]           w_bsel;
  logic [7:0]           w_send_byte;
  logic                 w_bit;
  logic [7:0]           w_rdata;

  always_comb begin
    // Borrow bit of the subtraction flags addresses below BASEADDR without a constant compare.
    w_diff      = {1'b0, BUS_ADD} - BASE_X;
    w_off       = w_diff[ABUSWIDTH-1:0];
    w_in_range  = !w_diff[ABUSWIDTH] && (w_off <= SPAN);
    w_is_mem    = (w_off >= MEM_LO) && (w_off < MEM_HI);
    w_is_reg    = (w_off < REG_HI);
    w_mem_addr  = AW'(w_off - MEM_LO);
    w_wr        = BUS_WR && w_in_range;
    w_soft_rst  = w_wr && w_is_reg && (w_off[2:0] == 3'd0);
    w_start     = (r_state == ST_IDLE) &&
                  ((w_wr && (w_off == OFF_STRT)) || (EXT_START && !r_ext_d && r_mode[0]));
    w_esize     = ({1'b0, r_size} > MEM_BITS) ? MEM_BITS : {1'b0, r_size};
    // A byte is fetched from memory on its first bit and held for the remaining seven.
    w_bsel      = r_idx[2:0];
    w_send_byte = (w_bsel == 3'd0) ? r_mem[r_idx[AW+2:3]] : r_byte;
    w_bit       = w_send_byte[3'd7 - w_bsel];

    w_rdata = '0;
    if (w_in_range) begin
      if (w_is_mem) begin
        w_rdata = r_mem[w_mem_addr];
      end else if (w_is_reg) begin
        case (w_off[2:0])
          3'd1:    w_rdata = {7'b0, r_ready};
          3'd2:    w_rdata = r_size[7:0];
          3'd3:    w_rdata = r_size[15:8];
          3'd4:    w_rdata = r_rep[7:0];
          3'd5:    w_rdata = r_rep[15:8];
          3'd6:    w_rdata = 8'(r_ch_en);
          3'd7:    w_rdata = {6'b0, r_mode};
          default: w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (w_wr && w_is_mem) r_mem[w_mem_addr] <= BUS_DATA_IN;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_state <= ST_IDLE;
      r_size  <= '0;
      r_rep   <= '0;
      r_ch_en <= '1;
      r_mode  <= '0;
      r_idx   <= '0;
      r_pass  <= '0;
      r_byte  <= '0;
      r_ext_d <= 1'b0;
      r_cmd   <= '0;
      r_ready <= 1'b1;
      r_flag  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ext_d <= EXT_START;
      if (BUS_RD) r_rdata <= w_rdata;

      if (w_wr && w_is_reg) begin
        case (w_off[2:0])
          3'd2:    r_size[7:0]  <= BUS_DATA_IN;
          3'd3:    r_size[15:8] <= BUS_DATA_IN;
          3'd4:    r_rep[7:0]   <= BUS_DATA_IN;
          3'd5:    r_rep[15:8]  <= BUS_DATA_IN;
          3'd6:    r_ch_en      <= BUS_DATA_IN[N_CH-1:0];
          3'd7:    r_mode       <= BUS_DATA_IN[1:0];
          default: ;
        endcase
      end

      r_cmd   <= '0;
      r_flag  <= 1'b0;
      r_ready <= (r_state == ST_IDLE);

      if (w_soft_rst) begin
        r_state <= ST_IDLE;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start && (w_esize != '0)) r_state <= ST_LOAD;
          end
          ST_LOAD: begin
            r_idx   <= '0;
            r_pass  <= '0;
            r_state <= ST_SEND;
          end
          ST_SEND: begin
            if (r_idx < w_esize) begin
              r_cmd  <= {N_CH{w_bit}} & r_ch_en;
              r_flag <= (r_idx == '0);
              if (w_bsel == 3'd0) r_byte <= w_send_byte;
            end
            // Pass ends on the last bit, or at once if SIZE shrank below the current index.
            if (r_idx + 17'd1 >= w_esize) begin
              if ((r_pass < {1'b0, r_rep}) || r_mode[1]) begin
                r_idx  <= '0;
                r_pass <= r_pass + 17'd1;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_idx <= r_idx + 17'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign CMD_DATA       = r_cmd;
  assign CMD_READY      = r_ready;
  assign CMD_START_FLAG = r_flag;
  assign BUS_DATA_OUT   = r_rdata;
endmodule
